pll_reset_sequencer: RTL

Reset and lock supervisor placed directly upstream of the core PLL. Runs on the free-running 74.25 MHz reference clock. Drives the PLL's `rst` input and monitors its asynchronous `locked` output. Releases the core reset only after lock has been continuously stable, and re-runs the PLL reset on lock loss, lock timeout, or software request.

---
 rtl/pll_reset_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// Reset and lock supervisor for the core PLL: pulses the PLL reset, waits for a
// stable synchronized lock, then releases the core reset; retries on loss/timeout.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_RESET     | pll_rst held high for RST_CYCLES cycles
// S_WAIT_LOCK | PLL running, waiting for lock; times out after LOCK_TIMEOUT
// S_SETTLE    | lock seen, must stay high for SETTLE_CYCLES cycles
// S_RUN       | core released; any lock loss restarts the PLL
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 742500,
  parameter int SETTLE_CYCLES = 1024,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       reset_req,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       pll_ready,
  output logic [7:0] lock_fail_count,
  output logic [1:0] state
);

  localparam int MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C  = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
  localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET     = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_SETTLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t cur, nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic locked_s;
  logic [CW-1:0] cnt, cnt_nxt;
  logic fail_inc;

  // pll_locked is asynchronous to clk_74a
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    nxt      = cur;
    fail_inc = 1'b0;
    if (reset_req) begin
      nxt = S_RESET;
    end else begin
      case (cur)
        S_RESET: begin
          if (cnt == RST_LAST) nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            nxt = S_SETTLE;
          end else if (cnt == TIMEOUT_LAST) begin
            nxt      = S_RESET;
            fail_inc = 1'b1;
          end
        end
        S_SETTLE: begin
          if (!locked_s)               nxt = S_WAIT_LOCK;
          else if (cnt == SETTLE_LAST) nxt = S_RUN;
        end
        S_RUN: begin
          if (!locked_s) nxt = S_RESET;
        end
        default: nxt = S_RESET;
      endcase
    end

    // Every state entry (including a reset_req restart) begins a fresh count
    if (reset_req || (nxt != cur)) cnt_nxt = '0;
    else if (cur == S_RUN)         cnt_nxt = cnt;
    else                           cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      cur             <= S_RESET;
      cnt             <= '0;
      pll_rst         <= 1'b1;
      core_reset_n    <= 1'b0;
      pll_ready       <= 1'b0;
      lock_fail_count <= 8'd0;
    end else begin
      cur          <= nxt;
      cnt          <= cnt_nxt;
      pll_rst      <= (nxt == S_RESET);
      core_reset_n <= (nxt == S_RUN);
      pll_ready    <= (nxt == S_RUN);
      if (fail_inc && (lock_fail_count != 8'hFF))
        lock_fail_count <= lock_fail_count + 8'd1;
    end
  end

  assign state = cur;

endmodule
